// File: rtl/gmii_tx_monitor.sv
// Per-port GMII transmit monitor: frame/gap length measurement, error counting, selectable readout.
// Latency: error pulse one cycle after the offending tx_en edge; readout registered, one cycle after port select.
// Backpressure: none, observe-only on tx_en; define TX_MON_MAX_GAP_CHECK_EN to also flag gaps above iv_max_gap.
module gmii_tx_monitor #(
    parameter int PORT_NUM  = 4,
    parameter int CNT_WIDTH = 32,
    parameter int GAP_WIDTH = 8,
    parameter int LEN_WIDTH = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [PORT_NUM-1:0]  iv_gmii_tx_en,
    input  logic [GAP_WIDTH-1:0] iv_min_gap,
    input  logic [GAP_WIDTH-1:0] iv_max_gap,
    input  logic [LEN_WIDTH-1:0] iv_expected_len,
    input  logic                 i_stat_clr,
    input  logic [7:0]           iv_port_sel,
    output logic [CNT_WIDTH-1:0] ov_pkt_cnt,
    output logic [CNT_WIDTH-1:0] ov_gap_err_cnt,
    output logic [CNT_WIDTH-1:0] ov_len_err_cnt,
    output logic [GAP_WIDTH-1:0] ov_last_gap,
    output logic [LEN_WIDTH-1:0] ov_last_len,
    output logic [PORT_NUM-1:0]  ov_err_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [GAP_WIDTH-1:0] sat_gap(input logic [GAP_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t               state_q [PORT_NUM];
    state_t               state_d [PORT_NUM];
    logic [LEN_WIDTH-1:0] len_q   [PORT_NUM];
    logic [LEN_WIDTH-1:0] len_d   [PORT_NUM];
    logic [GAP_WIDTH-1:0] gap_q   [PORT_NUM];
    logic [GAP_WIDTH-1:0] gap_d   [PORT_NUM];

    logic [CNT_WIDTH-1:0] pkt_cnt     [PORT_NUM];
    logic [CNT_WIDTH-1:0] gap_err_cnt [PORT_NUM];
    logic [CNT_WIDTH-1:0] len_err_cnt [PORT_NUM];
    logic [GAP_WIDTH-1:0] last_gap    [PORT_NUM];
    logic [LEN_WIDTH-1:0] last_len    [PORT_NUM];

    logic [PORT_NUM-1:0]  pkt_evt;
    logic [PORT_NUM-1:0]  len_err_evt;
    logic [PORT_NUM-1:0]  gap_err_evt;
    logic [PORT_NUM-1:0]  gap_ld;

    logic [CNT_WIDTH-1:0] rd_pkt;
    logic [CNT_WIDTH-1:0] rd_gap_err;
    logic [CNT_WIDTH-1:0] rd_len_err;
    logic [GAP_WIDTH-1:0] rd_last_gap;
    logic [LEN_WIDTH-1:0] rd_last_len;

`ifndef TX_MON_MAX_GAP_CHECK_EN
    logic unused_max_gap;
    assign unused_max_gap = ^iv_max_gap;
`endif

    // Next-state and event decode; thresholds are taken live at the transition cycle.
    always_comb begin
        pkt_evt     = '0;
        len_err_evt = '0;
        gap_err_evt = '0;
        gap_ld      = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            state_d[p] = state_q[p];
            len_d[p]   = len_q[p];
            gap_d[p]   = gap_q[p];
            case (state_q[p])
                ST_IDLE: begin
                    if (iv_gmii_tx_en[p]) begin
                        state_d[p] = ST_FRAME;
                        len_d[p]   = LEN_WIDTH'(1);
                    end
                end
                ST_FRAME: begin
                    if (iv_gmii_tx_en[p]) begin
                        len_d[p] = sat_len(len_q[p]);
                    end else begin
                        state_d[p]     = ST_GAP;
                        gap_d[p]       = GAP_WIDTH'(1);
                        pkt_evt[p]     = 1'b1;
                        len_err_evt[p] = (iv_expected_len != '0) && (len_q[p] != iv_expected_len);
                    end
                end
                ST_GAP: begin
                    if (!iv_gmii_tx_en[p]) begin
                        gap_d[p] = sat_gap(gap_q[p]);
                    end else begin
                        state_d[p] = ST_FRAME;
                        len_d[p]   = LEN_WIDTH'(1);
                        gap_ld[p]  = 1'b1;
`ifdef TX_MON_MAX_GAP_CHECK_EN
                        gap_err_evt[p] = (gap_q[p] < iv_min_gap) || (gap_q[p] > iv_max_gap);
`else
                        gap_err_evt[p] = (gap_q[p] < iv_min_gap);
`endif
                    end
                end
                default: begin
                    state_d[p] = ST_IDLE;
                end
            endcase
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_pkt      = '0;
        rd_gap_err  = '0;
        rd_len_err  = '0;
        rd_last_gap = '0;
        rd_last_len = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (iv_port_sel == 8'(p)) begin
                rd_pkt      = pkt_cnt[p];
                rd_gap_err  = gap_err_cnt[p];
                rd_len_err  = len_err_cnt[p];
                rd_last_gap = last_gap[p];
                rd_last_len = last_len[p];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                state_q[p]     <= ST_IDLE;
                len_q[p]       <= '0;
                gap_q[p]       <= '0;
                pkt_cnt[p]     <= '0;
                gap_err_cnt[p] <= '0;
                len_err_cnt[p] <= '0;
                last_gap[p]    <= '0;
                last_len[p]    <= '0;
            end
            ov_err_pulse <= '0;
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                state_q[p] <= state_d[p];
                len_q[p]   <= len_d[p];
                gap_q[p]   <= gap_d[p];
                // Clear takes priority over any increment or capture in the same cycle.
                if (i_stat_clr) begin
                    pkt_cnt[p]     <= '0;
                    gap_err_cnt[p] <= '0;
                    len_err_cnt[p] <= '0;
                    last_gap[p]    <= '0;
                    last_len[p]    <= '0;
                end else begin
                    if (pkt_evt[p]) begin
                        pkt_cnt[p]  <= sat_cnt(pkt_cnt[p]);
                        last_len[p] <= len_q[p];
                    end
                    if (len_err_evt[p]) begin
                        len_err_cnt[p] <= sat_cnt(len_err_cnt[p]);
                    end
                    if (gap_ld[p]) begin
                        last_gap[p] <= gap_q[p];
                    end
                    if (gap_err_evt[p]) begin
                        gap_err_cnt[p] <= sat_cnt(gap_err_cnt[p]);
                    end
                end
            end
            ov_err_pulse <= len_err_evt | gap_err_evt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_pkt_cnt     <= '0;
            ov_gap_err_cnt <= '0;
            ov_len_err_cnt <= '0;
            ov_last_gap    <= '0;
            ov_last_len    <= '0;
        end else begin
            ov_pkt_cnt     <= rd_pkt;
            ov_gap_err_cnt <= rd_gap_err;
            ov_len_err_cnt <= rd_len_err;
            ov_last_gap    <= rd_last_gap;
            ov_last_len    <= rd_last_len;
        end
    end

endmodule

// File: tb/tb_gmii_tx_monitor.sv
// Scenario bench for gmii_tx_monitor: scripted tx_en patterns, per-cycle pulse checks, queued readout expectations.
module tb_gmii_tx_monitor;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [3:0]  iv_gmii_tx_en = '0;
    logic [7:0]  iv_min_gap = 8'd12;
    logic [7:0]  iv_max_gap = 8'd255;
    logic [11:0] iv_expected_len = 12'd75;
    logic        i_stat_clr = 1'b0;
    logic [7:0]  iv_port_sel = '0;
    logic [31:0] ov_pkt_cnt;
    logic [31:0] ov_gap_err_cnt;
    logic [31:0] ov_len_err_cnt;
    logic [7:0]  ov_last_gap;
    logic [11:0] ov_last_len;
    logic [3:0]  ov_err_pulse;

    gmii_tx_monitor dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .iv_gmii_tx_en  (iv_gmii_tx_en),
        .iv_min_gap     (iv_min_gap),
        .iv_max_gap     (iv_max_gap),
        .iv_expected_len(iv_expected_len),
        .i_stat_clr     (i_stat_clr),
        .iv_port_sel    (iv_port_sel),
        .ov_pkt_cnt     (ov_pkt_cnt),
        .ov_gap_err_cnt (ov_gap_err_cnt),
        .ov_len_err_cnt (ov_len_err_cnt),
        .ov_last_gap    (ov_last_gap),
        .ov_last_len    (ov_last_len),
        .ov_err_pulse   (ov_err_pulse)
    );

    always #4 i_clk = ~i_clk;

    typedef struct {
        int          port;
        logic [31:0] pkt;
        logic [31:0] gerr;
        logic [31:0] lerr;
        logic [31:0] lgap;
        logic [31:0] llen;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive a constant tx_en pattern for n cycles; pulse_first is the error pulse the
    // entry transition of this segment must produce, all later cycles expect none.
    task automatic run(input logic [3:0] en, input int n, input logic [3:0] pulse_first,
                       input logic clr = 1'b0);
        for (int i = 0; i < n; i++) begin
            iv_gmii_tx_en = en;
            i_stat_clr    = (i == 0) ? clr : 1'b0;
            tick();
            i_stat_clr    = 1'b0;
            chk("err_pulse", 32'(ov_err_pulse), (i == 0) ? 32'(pulse_first) : 32'h0);
        end
    endtask

    task automatic push_exp(input int port, input int pkt, input int gerr, input int lerr,
                            input int lgap, input int llen);
        exp_t e;
        e.port = port;
        e.pkt  = 32'(pkt);
        e.gerr = 32'(gerr);
        e.lerr = 32'(lerr);
        e.lgap = 32'(lgap);
        e.llen = 32'(llen);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            iv_port_sel = 8'(e.port);
            tick();
            chk($sformatf("p%0d_pkt", e.port), ov_pkt_cnt, e.pkt);
            chk($sformatf("p%0d_gap_err", e.port), ov_gap_err_cnt, e.gerr);
            chk($sformatf("p%0d_len_err", e.port), ov_len_err_cnt, e.lerr);
            chk($sformatf("p%0d_last_gap", e.port), 32'(ov_last_gap), e.lgap);
            chk($sformatf("p%0d_last_len", e.port), 32'(ov_last_len), e.llen);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pkt"}, ov_pkt_cnt, 32'h0);
        chk({tag, "_gap_err"}, ov_gap_err_cnt, 32'h0);
        chk({tag, "_len_err"}, ov_len_err_cnt, 32'h0);
        chk({tag, "_last_gap"}, 32'(ov_last_gap), 32'h0);
        chk({tag, "_last_len"}, 32'(ov_last_len), 32'h0);
        chk({tag, "_pulse"}, 32'(ov_err_pulse), 32'h0);
    endtask

    initial begin
        int exp_gerr_max;
`ifdef TX_MON_MAX_GAP_CHECK_EN
        exp_gerr_max = 1;
`else
        exp_gerr_max = 0;
`endif
        tick();
        tick();
        chk_all_zero("rst");
        i_rst_n = 1'b1;
        push_exp(0, 0, 0, 0, 0, 0);
        drain();

        // Port0: two 75-cycle frames, 12-cycle gap, all within limits.
        run(4'b0001, 75, 4'b0000);
        run(4'b0000, 12, 4'b0000);
        run(4'b0001, 75, 4'b0000);
        run(4'b0000, 1, 4'b0000);
        push_exp(0, 2, 0, 0, 12, 75);
        drain();

        // Port1: short gap flagged on the rising edge, legal gap afterwards.
        iv_expected_len = 12'd0;
        run(4'b0010, 5, 4'b0000);
        run(4'b0000, 10, 4'b0000);
        run(4'b0010, 5, 4'b0010);
        run(4'b0000, 14, 4'b0000);
        run(4'b0010, 5, 4'b0000);
        run(4'b0000, 1, 4'b0000);
        push_exp(1, 3, 1, 0, 14, 5);
        drain();

        // Port2: 74-cycle frame against 75 expected, then against a disabled check.
        iv_expected_len = 12'd75;
        run(4'b0100, 74, 4'b0000);
        run(4'b0000, 1, 4'b0100);
        push_exp(2, 1, 0, 1, 0, 74);
        drain();
        iv_expected_len = 12'd0;
        run(4'b0000, 300, 4'b0000);
        run(4'b0100, 74, 4'b0000);
        run(4'b0000, 1, 4'b0000);
        push_exp(2, 2, 0, 1, 255, 74);
        drain();

        // Ports 0 and 3 both raise length errors while stats are cleared.
        iv_expected_len = 12'd75;
        run(4'b1001, 10, 4'b0000);
        run(4'b0000, 1, 4'b1001, 1'b1);
        push_exp(0, 0, 0, 0, 0, 0);
        push_exp(3, 0, 0, 0, 0, 0);
        push_exp(1, 0, 0, 0, 0, 0);
        push_exp(2, 0, 0, 0, 0, 0);
        drain();

        // Port3: 300-cycle gap saturates; flagged only when the max-gap check is built in.
        iv_max_gap      = 8'd200;
        iv_expected_len = 12'd0;
        run(4'b0000, 300, 4'b0000);
        run(4'b1000, 5, (exp_gerr_max != 0) ? 4'b1000 : 4'b0000);
        run(4'b0000, 1, 4'b0000);
        iv_max_gap = 8'd255;
        push_exp(3, 1, exp_gerr_max, 0, 255, 5);
        drain();

        // Port0: reset lands mid-frame, frame re-measured from the first cycle after release.
        run(4'b0001, 30, 4'b0000);
        chk("pre_rst_pkt", ov_pkt_cnt, 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        tick();
        i_rst_n = 1'b1;
        run(4'b0001, 20, 4'b0000);
        run(4'b0000, 1, 4'b0000);
        push_exp(0, 1, 0, 0, 0, 20);
        push_exp(3, 0, 0, 0, 0, 0);
        push_exp(9, 0, 0, 0, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/gmii_tx_monitor.md
GMII_TX_MONITOR -- requirements
Module: gmii_tx_monitor

Interface
REQ-001 SHALL have parameter PORT_NUM, default 4, number of monitored GMII transmit ports.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each statistics counter.
REQ-003 SHALL have parameter GAP_WIDTH, default 8, width of gap counters and gap thresholds.
REQ-004 SHALL have parameter LEN_WIDTH, default 12, width of frame-length counters and expected length.
REQ-005 SHALL have i_clk, input, 1, 125 MHz clock; one clock, all logic in this domain.
REQ-006 SHALL have i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have iv_gmii_tx_en, input, PORT_NUM, per-port tx enable, synchronous to i_clk.
REQ-008 SHALL have iv_min_gap, input, GAP_WIDTH, minimum legal inter-frame gap in cycles.
REQ-009 SHALL have iv_max_gap, input, GAP_WIDTH, maximum legal gap (used only under REQ-030).
REQ-010 SHALL have iv_expected_len, input, LEN_WIDTH, expected frame length in cycles; 0 disables length check.
REQ-011 SHALL have i_stat_clr, input, 1, single-cycle pulse clearing all statistics.
REQ-012 SHALL have iv_port_sel, input, 8, port index for readout.
REQ-013 SHALL have ov_pkt_cnt / ov_gap_err_cnt / ov_len_err_cnt, output, CNT_WIDTH each, selected-port counters.
REQ-014 SHALL have ov_last_gap (GAP_WIDTH) and ov_last_len (LEN_WIDTH), outputs, last measured values of selected port.
REQ-015 SHALL have ov_err_pulse, output, PORT_NUM, one-cycle per-port error indication.

Function
REQ-016 Per port SHALL run an FSM with states IDLE, FRAME, GAP; IDLE after reset, no gap measured before the first frame.
REQ-017 IDLE: tx_en=1 -> FRAME, len_cnt<=1; else stay.
REQ-018 FRAME: tx_en=1 -> len_cnt+1, saturating at all-ones; tx_en=0 -> GAP, gap_cnt<=1, last_len<=len_cnt, pkt_cnt+1.
REQ-019 On FRAME->GAP, if iv_expected_len!=0 and len_cnt!=iv_expected_len, len_err_cnt SHALL increment and ov_err_pulse[port] SHALL assert next cycle for one cycle.
REQ-020 GAP: tx_en=0 -> gap_cnt+1, saturating at all-ones; tx_en=1 -> FRAME, len_cnt<=1, last_gap<=gap_cnt.
REQ-021 On GAP->FRAME, gap_cnt<iv_min_gap SHALL increment gap_err_cnt and pulse ov_err_pulse[port] next cycle.
REQ-022 Length and gap errors on the same port in the same cycle are impossible; simultaneous events on different ports SHALL be counted independently.
REQ-023 All statistics counters SHALL saturate at all-ones, never wrap.
REQ-024 i_stat_clr SHALL zero pkt/gap_err/len_err counters and last_gap/last_len of all ports next cycle; FSM state and running len_cnt/gap_cnt unaffected; clear wins over a coincident increment.
REQ-025 Readout outputs SHALL be registered: value of port iv_port_sel sampled at edge N appears after edge N (1-cycle latency).
REQ-026 iv_port_sel>=PORT_NUM SHALL drive all readout outputs to 0.
REQ-027 Threshold inputs SHALL be sampled at the comparison cycle; changes mid-frame apply to the next comparison.

Reset
REQ-028 i_rst_n low SHALL immediately force all FSMs to IDLE and all counters, last values, readout outputs and ov_err_pulse to 0.
REQ-029 Reset deasserted mid-frame: port SHALL wait in IDLE for tx_en=1; an in-progress frame (tx_en already 1) is counted from the first high cycle after reset, with length measured from that cycle.

Configuration
REQ-030 Macro TX_MON_MAX_GAP_CHECK_EN defined: on GAP->FRAME, gap_cnt>iv_max_gap SHALL also count as gap error (same counter, same pulse); undefined: iv_max_gap ignored, only minimum check.

Verification
REQ-031 Port0: frame 75 cycles, gap 12, frame 75; expected_len=75, min_gap=12 -> pkt_cnt=2, gap_err=0, len_err=0, last_gap=12.
REQ-032 Port1: gap 10 then gap 14 with min_gap=12 -> gap_err=1, ov_err_pulse[1] exactly one cycle after the first rising edge following gap 10.
REQ-033 Port2: frame 74 cycles, expected_len=75 -> len_err=1, last_len=74; same with expected_len=0 -> len_err=0.
REQ-034 Ports 0 and 3 error in the same cycle, i_stat_clr asserted that cycle -> all counters 0, both pulses still assert.
REQ-035 Gap of 300 cycles, GAP_WIDTH=8 -> last_gap=255; with TX_MON_MAX_GAP_CHECK_EN and max_gap=200 -> gap_err=1, without -> 0.
REQ-036 Reset asserted mid-frame on port0, released with tx_en high 20 more cycles -> pkt_cnt=1, last_len=20; iv_port_sel=9 -> all readout 0.
